rst_mgr: RTL

RST_MGR -- requirements
Module: rst_mgr

---
 rtl/rst_mgr.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rst_mgr.sv
// ---------------------------------------------------------------------------
// rst_mgr
//
// Reset manager. It gathers the reset sources (board reset, push-button,
// software request and CPU trap), holds every reset domain asserted for a
// fixed time, and then releases the domains one at a time in index order.
//
// Ports
//   clk          : sole clock, all state changes on its rising edge
//   rst          : board / power-on reset, synchronous, active-high
//   ext_rst_req  : asynchronous push-button request, active-high level
//   sw_rst_req   : single-cycle software reset request
//   trap         : CPU trap flag, its rising edge requests a reset
//   trap_rst_en  : enables trap-triggered resets
//   rst_out      : active-high reset per domain, bit 0 released first
//   rst_cause    : last reset source (0 rst, 1 ext, 2 trap, 3 sw)
//   ready        : high once every rst_out bit is deasserted
// ---------------------------------------------------------------------------
module rst_mgr #(
    parameter int N_RST       = 2,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 65535,
    parameter int STAGGER     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_rst_req,
    input  logic             sw_rst_req,
    input  logic             trap,
    input  logic             trap_rst_en,
    output logic [N_RST-1:0] rst_out,
    output logic [1:0]       rst_cause,
    output logic             ready
);

    localparam int IDX_W = (N_RST > 1) ? $clog2(N_RST) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_RST - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       hcnt;
    logic [CNT_W-1:0]       scnt;
    logic [IDX_W-1:0]       idx;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_s;
    logic                   trap_q;
    logic                   trap_req;
    logic                   req;

    // The push-button is asynchronous, so it is brought into the clock
    // domain through a plain flop chain before anything looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_req};
        end
    end

    assign ext_s = sync_q[SYNC_STAGES-1];

    // Delayed copy of trap, used to act only on its rising edge so that a
    // trap flag left high produces a single reset event.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap;
        end
    end

    assign trap_req = trap_rst_en & trap & ~trap_q;
    assign req      = ext_s | sw_rst_req | trap_req;

    // Main sequencer. Any request restarts the hold period from the top,
    // which also means a held ext_s keeps reloading the hold counter and
    // the countdown only begins once it drops. Bits are only ever cleared
    // one at a time in index order and are only set again all together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HOLD;
            hcnt      <= HOLD_LOAD;
            scnt      <= '0;
            idx       <= '0;
            rst_out   <= '1;
            ready     <= 1'b0;
            rst_cause <= 2'd0;
        end else if (req) begin
            state   <= HOLD;
            hcnt    <= HOLD_LOAD;
            rst_out <= '1;
            ready   <= 1'b0;
            if (ext_s) begin
                rst_cause <= 2'd1;
            end else if (trap_req) begin
                rst_cause <= 2'd2;
            end else begin
                rst_cause <= 2'd3;
            end
        end else begin
            case (state)
                HOLD: begin
                    if (hcnt != '0) begin
                        hcnt <= hcnt - CNT_W'(1);
                    end else begin
                        rst_out[0] <= 1'b0;
                        if (N_RST == 1) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            idx   <= IDX_W'(1);
                            scnt  <= STAG_LOAD;
                        end
                    end
                end
                RELEASE: begin
                    if (scnt != '0) begin
                        scnt <= scnt - CNT_W'(1);
                    end else begin
                        rst_out[idx] <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            scnt <= STAG_LOAD;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
